// File: rtl/fd_pkg.sv
// Shared state encoding and run-mode constants for the frame-capture / detection sequencer.
package fd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ARM    = 3'd1;
  localparam state_t S_FILL   = 3'd2;
  localparam state_t S_DETECT = 3'd3;
  localparam state_t S_EVAL   = 3'd4;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;

endpackage

// File: rtl/detect_sequencer_if.sv
// Control, capture, cascade and BRAM port-A signals around the detection sequencer.
interface detect_sequencer_if #(
  parameter int ADDR_W     = 15,
  parameter int CLS_ADDR_W = 20,
  parameter int N_CH       = 2,
  parameter int CNT_W      = 8
);
  logic [1:0]               mode;
  logic [CNT_W-1:0]         burst_len;
  logic                     go;
  logic                     cap_we;
  logic [ADDR_W-1:0]        cap_addr;
  logic                     cap_done;
  logic [N_CH*CLS_ADDR_W-1:0] cls_addr;
  logic [N_CH-1:0]          det_done;
  logic [N_CH-1:0]          det_hit;
  logic [N_CH-1:0]          det_en;
  logic [ADDR_W-1:0]        bram_addr;
  logic                     bram_we;
  logic                     busy;
  logic                     detected;
  logic [CNT_W-1:0]         frame_cnt;
  logic [CNT_W-1:0]         hit_cnt;
  logic                     timeout_err;

  modport master (
    input  mode, burst_len, go, cap_we, cap_addr, cap_done, cls_addr, det_done, det_hit,
    output det_en, bram_addr, bram_we, busy, detected, frame_cnt, hit_cnt, timeout_err
  );

  modport slave (
    output mode, burst_len, go, cap_we, cap_addr, cap_done, cls_addr, det_done, det_hit,
    input  det_en, bram_addr, bram_we, busy, detected, frame_cnt, hit_cnt, timeout_err
  );
endinterface

// File: rtl/det_watchdog.sv
// Per-engine watchdog: counts enabled cycles, expires on the cycle that completes 2**TMO_W-1.
module det_watchdog #(
  parameter int TMO_W = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + TMO_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_en) r_cnt <= '0;
    else                         r_cnt <= w_cnt_inc;
  end

  // r_cnt holds the cycles already spent, so the current cycle is number r_cnt+1
  assign o_expired = i_en && (&w_cnt_inc);
endmodule

// File: rtl/detect_sequencer.sv
// Frame capture / detection sequencer: owns BRAM port A and runs N_CH cascades in turn on one frame.
//   state  | meaning
//   IDLE   | waiting for go
//   ARM    | dropping a possibly partial frame, writes blocked
//   FILL   | capture writes the frame into the BRAM
//   DETECT | cascade r_ch owns the BRAM read port
//   EVAL   | one cycle: publish frame result, update statistics
module detect_sequencer
  import fd_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int CLS_ADDR_W = 20,
  parameter int N_CH       = 2,
  parameter int TMO_W      = 24,
  parameter int CNT_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  detect_sequencer_if.master bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t           r_state, w_state_nxt;
  logic [CH_W-1:0]  r_ch;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_frames_left;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             r_frame_hit;
  logic             r_detected;
  logic             r_timeout_err;

  logic             w_in_detect;
  logic             w_done_sel;
  logic             w_last_ch;
  logic             w_expired;
  logic [N_CH-1:0]  w_det_en;
  logic [ADDR_W-1:0] w_bram_addr;
  logic             w_bram_we;

  assign w_in_detect = (r_state == S_DETECT);
  assign w_done_sel  = w_in_detect && bus.det_done[r_ch];
  assign w_last_ch   = (r_ch == LAST_CH);

  det_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_done_sel),
    .i_en      (w_in_detect),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.go) w_state_nxt = S_ARM;
      S_ARM:    if (bus.cap_done) w_state_nxt = S_FILL;
      S_FILL:   if (bus.cap_done) w_state_nxt = S_DETECT;
      S_DETECT: begin
        // a done pulse landing on the expiry cycle still counts as on time
        if (w_done_sel) begin
          if (w_last_ch) w_state_nxt = S_EVAL;
        end else if (w_expired) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EVAL: begin
        if (r_mode == MODE_CONT && bus.mode == MODE_CONT)        w_state_nxt = S_ARM;
        else if (r_mode == MODE_BURST && r_frames_left > CNT_W'(1)) w_state_nxt = S_ARM;
        else                                                      w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_det_en    = '0;
    w_bram_addr = '0;
    w_bram_we   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_bram_we   = bus.cap_we;
        w_bram_addr = bus.cap_addr;
      end
      S_DETECT: begin
        w_det_en[r_ch] = 1'b1;
        w_bram_addr    = bus.cls_addr[r_ch*CLS_ADDR_W +: ADDR_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ch          <= '0;
      r_mode        <= MODE_SINGLE;
      r_frames_left <= '0;
      r_frame_cnt   <= '0;
      r_hit_cnt     <= '0;
      r_frame_hit   <= 1'b0;
      r_detected    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.go) begin
          r_mode        <= (bus.mode == MODE_CONT || bus.mode == MODE_BURST) ? bus.mode : MODE_SINGLE;
          r_frames_left <= (bus.mode == MODE_BURST && bus.burst_len != '0) ? bus.burst_len : CNT_W'(1);
          r_frame_hit   <= 1'b0;
        end
        S_FILL: if (bus.cap_done) r_ch <= '0;
        S_DETECT: begin
          if (w_done_sel) begin
            r_frame_hit <= r_frame_hit | bus.det_hit[r_ch];
            if (!w_last_ch) r_ch <= r_ch + CH_W'(1);
          end else if (w_expired) begin
            r_timeout_err <= 1'b1;
            r_frame_hit   <= 1'b0;
          end
        end
        S_EVAL: begin
          r_detected    <= r_frame_hit;
          r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
          r_hit_cnt     <= r_hit_cnt + CNT_W'(r_frame_hit);
          r_frame_hit   <= 1'b0;
          r_frames_left <= r_frames_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.det_en      = w_det_en;
  assign bus.bram_addr   = w_bram_addr;
  assign bus.bram_we     = w_bram_we;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.detected    = r_detected;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.hit_cnt     = r_hit_cnt;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_detect_sequencer.sv
// Directed scenarios with randomized pixels, addresses, latencies and hits against a frame-level model.
module tb_detect_sequencer;
  localparam int ADDR_W     = 15;
  localparam int CLS_ADDR_W = 20;
  localparam int N_CH       = 2;
  localparam int TMO_W      = 4;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  detect_sequencer_if #(.ADDR_W(ADDR_W), .CLS_ADDR_W(CLS_ADDR_W), .N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  detect_sequencer #(
    .ADDR_W(ADDR_W), .CLS_ADDR_W(CLS_ADDR_W), .N_CH(N_CH), .TMO_W(TMO_W), .CNT_W(CNT_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_fc  = 0;
  int m_hc  = 0;
  bit m_det  = 1'b0;
  bit m_terr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // next cycle: pulses dropped, fresh random cascade addresses
  task automatic step();
    logic [63:0] r64;
    @(negedge clk);
    r64 = {$urandom(), $urandom()};
    bus.go       = 1'b0;
    bus.cap_we   = 1'b0;
    bus.cap_done = 1'b0;
    bus.det_done = '0;
    bus.det_hit  = '0;
    bus.cls_addr = r64[N_CH*CLS_ADDR_W-1:0];
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_detected"}, 32'(bus.detected), 32'(m_det));
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(m_fc % 256));
    chk({tag, "_hit_cnt"}, 32'(bus.hit_cnt), 32'(m_hc % 256));
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'(m_terr));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_det_en"}, 32'(bus.det_en), 32'd0);
    chk({tag, "_bram_we"}, 32'(bus.bram_we), 32'd0);
    chk({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk_stats(tag);
  endtask

  task automatic go_cmd(input logic [1:0] mode, input logic [CNT_W-1:0] bl);
    step();
    bus.mode      = mode;
    bus.burst_len = bl;
    bus.go        = 1'b1;
    #1;
    chk("go_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  // one capture frame ending with cap_done; stored selects FILL (written) vs ARM (blocked)
  task automatic drive_frame(input int npix, input bit stored);
    for (int i = 0; i < npix; i++) begin
      step();
      bus.cap_we   = 1'($urandom());
      bus.cap_addr = ADDR_W'($urandom());
      #1;
      chk("frame_busy", 32'(bus.busy), 32'd1);
      if (stored) begin
        chk("fill_we", 32'(bus.bram_we), 32'(bus.cap_we));
        chk("fill_addr", 32'(bus.bram_addr), 32'(bus.cap_addr));
      end else begin
        chk("arm_we", 32'(bus.bram_we), 32'd0);
      end
    end
    step();
    bus.cap_done = 1'b1;
    #1;
  endtask

  // engines answer in order after d[ch] idle cycles; noise on other channel and cap_done
  task automatic run_detect(input int d0, input int d1, input logic [1:0] hits, output bit fh);
    logic [N_CH*CLS_ADDR_W-1:0] cv;
    int d;
    int oth;
    fh = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      d   = (ch == 0) ? d0 : d1;
      oth = 1 - ch;
      for (int k = 0; k <= d; k++) begin
        step();
        if ($urandom_range(0, 2) == 0) begin
          bus.det_done[oth] = 1'b1;
          bus.det_hit[oth]  = 1'b1;
        end
        bus.cap_done = 1'($urandom());
        bus.go       = 1'($urandom());
        if (k == d) begin
          bus.det_done[ch] = 1'b1;
          bus.det_hit[ch]  = hits[ch];
          fh = fh | hits[ch];
        end
        #1;
        cv = bus.cls_addr;
        chk("det_en", 32'(bus.det_en), 32'(1 << ch));
        chk("det_we", 32'(bus.bram_we), 32'd0);
        chk("det_addr", 32'(bus.bram_addr), 32'(cv[ch*CLS_ADDR_W +: ADDR_W]));
      end
    end
  endtask

  task automatic do_frame(input logic [1:0] hits, input int d0, input int d1);
    bit fh;
    drive_frame($urandom_range(2, 6), 1'b1);
    run_detect(d0, d1, hits, fh);
    step();
    #1;
    chk("eval_busy", 32'(bus.busy), 32'd1);
    chk("eval_det_en", 32'(bus.det_en), 32'd0);
    chk("eval_we", 32'(bus.bram_we), 32'd0);
    m_fc++;
    if (fh) m_hc++;
    m_det = fh;
  endtask

  task automatic after_eval(input bit exp_busy);
    step();
    #1;
    chk("post_eval_busy", 32'(bus.busy), 32'(exp_busy));
    chk_stats("post_eval");
  endtask

  initial begin
    bus.mode      = 2'b00;
    bus.burst_len = '0;
    bus.cap_addr  = '0;
    bus.go        = 1'b0;
    bus.cap_we    = 1'b0;
    bus.cap_done  = 1'b0;
    bus.det_done  = '0;
    bus.det_hit   = '0;
    bus.cls_addr  = '0;
    repeat (3) step();
    #1;
    chk_reset("por");
    rst = 1'b0;

    // single: go arrives mid-frame, that frame is dropped, next one stored
    for (int i = 0; i < 6; i++) begin
      step();
      bus.cap_we   = 1'($urandom());
      bus.cap_addr = ADDR_W'($urandom());
      if (i == 2) bus.go = 1'b1;
      #1;
      chk("pre_arm_we", 32'(bus.bram_we), 32'd0);
      chk("pre_arm_busy", 32'(bus.busy), 32'(i > 2));
    end
    drive_frame(4, 1'b0);
    do_frame(2'b10, $urandom_range(0, 10), $urandom_range(0, 10));
    after_eval(1'b0);

    // burst of three, no hits
    go_cmd(2'b10, CNT_W'(3));
    for (int f = 0; f < 3; f++) begin
      drive_frame(3, 1'b0);
      do_frame(2'b00, $urandom_range(0, 10), $urandom_range(0, 10));
      after_eval(f < 2);
    end

    // burst_len 0 runs exactly one frame
    go_cmd(2'b10, CNT_W'(0));
    drive_frame(3, 1'b0);
    do_frame(2'b01, $urandom_range(0, 10), $urandom_range(0, 10));
    after_eval(1'b0);

    // reset while in DETECT with five frames counted
    go_cmd(2'b00, CNT_W'(0));
    drive_frame(3, 1'b0);
    drive_frame(3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("pre_rst_det_en", 32'(bus.det_en), 32'd1);
    end
    chk("pre_rst_frame_cnt", 32'(bus.frame_cnt), 32'd5);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    m_fc = 0; m_hc = 0; m_det = 1'b0; m_terr = 1'b0;
    chk_reset("rst_detect");
    go_cmd(2'b00, CNT_W'(0));
    drive_frame(3, 1'b0);
    do_frame(2'($urandom()), $urandom_range(0, 10), $urandom_range(0, 10));
    after_eval(1'b0);

    // continuous, mode leaves 01 during the fourth frame
    go_cmd(2'b01, CNT_W'(0));
    for (int f = 1; f <= 4; f++) begin
      drive_frame(3, 1'b0);
      if (f == 4) bus.mode = 2'b00;
      do_frame(2'($urandom()), $urandom_range(0, 10), $urandom_range(0, 10));
      after_eval(f < 4);
    end
    chk("cont_frames", 32'(bus.frame_cnt), 32'd5);

    // done on the last allowed cycle of each engine is on time
    go_cmd(2'b00, CNT_W'(0));
    drive_frame(3, 1'b0);
    do_frame(2'b00, 14, 14);
    after_eval(1'b0);

    // engine 1 never answers: frame discarded, sticky error
    go_cmd(2'b00, CNT_W'(0));
    drive_frame(3, 1'b0);
    drive_frame(3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        bus.det_done = 2'b01;
        bus.det_hit  = 2'b01;
      end
      #1;
      chk("tmo_ch0_en", 32'(bus.det_en), 32'd1);
    end
    for (int k = 0; k < 15; k++) begin
      step();
      #1;
      chk("tmo_ch1_en", 32'(bus.det_en), 32'd2);
    end
    step();
    #1;
    m_terr = 1'b1;
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_det_en", 32'(bus.det_en), 32'd0);
    chk_stats("tmo");

    // sequencer still usable after a timeout
    go_cmd(2'b00, CNT_W'(0));
    drive_frame(3, 1'b0);
    do_frame(2'($urandom()), $urandom_range(0, 10), $urandom_range(0, 10));
    after_eval(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
